// File: rtl/snake_pkg.sv
// Shared codes for the snake game: per-pixel collision states and game FSM encoding.
package snake_pkg;

  localparam logic [1:0] COLL_RESET = 2'b00;
  localparam logic [1:0] COLL_HIT   = 2'b01;
  localparam logic [1:0] COLL_APPLE = 2'b10;
  localparam logic [1:0] COLL_NONE  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLACE = 2'd1,
    RUN   = 2'd2,
    OVER  = 2'd3
  } state_e;

endpackage

// File: rtl/apple_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), free-running every clock.
// Supplies candidate apple coordinates; SEED must be nonzero.
module apple_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] state_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_o <= SEED;
    end else begin
      state_o <= {state_o[14:0], state_o[15] ^ state_o[13] ^ state_o[12] ^ state_o[10]};
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Snake game controller: latches per-frame collision/apple events, acts at frame end.
// Optional high-score register enabled by defining HIGH_SCORE_EN.
module game_ctrl
  import snake_pkg::*;
#(
  parameter int          GRID_W    = 32,
  parameter int          GRID_H    = 24,
  parameter int          COORD_W   = 6,
  parameter int          LEN_W     = 6,
  parameter int          INIT_LEN  = 3,
  parameter int          MAX_LEN   = 63,
  parameter int          SCORE_W   = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         coll_state_i,
  input  logic               frame_end_i,
  input  logic               start_i,
  output logic               run_o,
  output logic               game_over_o,
  output logic               grow_o,
  output logic [LEN_W-1:0]   snake_len_o,
  output logic [SCORE_W-1:0] score_o,
  output logic [SCORE_W-1:0] hi_score_o,
  output logic               apple_vld_o,
  output logic [COORD_W-1:0] apple_x_o,
  output logic [COORD_W-1:0] apple_y_o
);

  state_e             state;
  logic [15:0]        lfsr;
  logic [COORD_W-1:0] cand_x;
  logic [COORD_W-1:0] cand_y;
  logic               cand_ok;
  logic               unused_lfsr_hi;
  logic               active;
  logic               coll_hit;
  logic               coll_apple;
  logic               hit_c;
  logic               hit_a;
  logic               hit_c_now;
  logic               hit_a_now;
  logic               enter_over;

  apple_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .state_o (lfsr)
  );

  assign cand_x         = lfsr[COORD_W-1:0];
  assign cand_y         = lfsr[2*COORD_W-1:COORD_W];
  assign unused_lfsr_hi = ^lfsr[15:2*COORD_W];
  assign cand_ok        = (int'(cand_x) < GRID_W) && (int'(cand_y) < GRID_H);

  assign active = (state == PLACE) || (state == RUN);

  always_comb begin
    coll_hit   = 1'b0;
    coll_apple = 1'b0;
    case (coll_state_i)
      COLL_HIT:              coll_hit   = 1'b1;
      COLL_APPLE:            coll_apple = 1'b1;
      COLL_RESET, COLL_NONE: ;
      default:               ;
    endcase
  end

  // The frame_end cycle's own pixel counts toward the decision.
  assign hit_c_now  = hit_c | (active & coll_hit);
  assign hit_a_now  = hit_a | (active & coll_apple);
  assign enter_over = active && frame_end_i && hit_c_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      run_o       <= 1'b0;
      game_over_o <= 1'b0;
      grow_o      <= 1'b0;
      snake_len_o <= LEN_W'(INIT_LEN);
      score_o     <= '0;
      apple_vld_o <= 1'b0;
      apple_x_o   <= '0;
      apple_y_o   <= '0;
      hit_c       <= 1'b0;
      hit_a       <= 1'b0;
    end else begin
      grow_o <= 1'b0;

      if (frame_end_i || !active) begin
        hit_c <= 1'b0;
        hit_a <= 1'b0;
      end else begin
        hit_c <= hit_c_now;
        hit_a <= hit_a_now;
      end

      case (state)
        IDLE, OVER: begin
          if (start_i) begin
            state       <= PLACE;
            run_o       <= 1'b1;
            game_over_o <= 1'b0;
            snake_len_o <= LEN_W'(INIT_LEN);
            score_o     <= '0;
            apple_vld_o <= 1'b0;
          end
        end
        PLACE: begin
          if (enter_over) begin
            state       <= OVER;
            run_o       <= 1'b0;
            game_over_o <= 1'b1;
          end else if (cand_ok) begin
            apple_x_o   <= cand_x;
            apple_y_o   <= cand_y;
            apple_vld_o <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          if (enter_over) begin
            state       <= OVER;
            run_o       <= 1'b0;
            game_over_o <= 1'b1;
          end else if (frame_end_i && hit_a_now) begin
            grow_o      <= 1'b1;
            apple_vld_o <= 1'b0;
            state       <= PLACE;
            if (snake_len_o != LEN_W'(MAX_LEN))
              snake_len_o <= snake_len_o + 1'b1;
            if (score_o != {SCORE_W{1'b1}})
              score_o <= score_o + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HIGH_SCORE_EN
  // Best score survives restarts; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_score_o <= '0;
    end else if (enter_over && (score_o > hi_score_o)) begin
      hi_score_o <= score_o;
    end
  end
`else
  assign hi_score_o = '0;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: stimulus pushes expected events, a negedge monitor pops and checks.
module tb_game_ctrl;
  import snake_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] coll_state_i = COLL_NONE;
  logic       frame_end_i = 1'b0;
  logic       start_i = 1'b0;
  logic       run_o, game_over_o, grow_o, apple_vld_o;
  logic [5:0] snake_len_o, apple_x_o, apple_y_o;
  logic [7:0] score_o, hi_score_o;

  game_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .coll_state_i (coll_state_i),
    .frame_end_i  (frame_end_i),
    .start_i      (start_i),
    .run_o        (run_o),
    .game_over_o  (game_over_o),
    .grow_o       (grow_o),
    .snake_len_o  (snake_len_o),
    .score_o      (score_o),
    .hi_score_o   (hi_score_o),
    .apple_vld_o  (apple_vld_o),
    .apple_x_o    (apple_x_o),
    .apple_y_o    (apple_y_o)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_GROW = 1, EV_OVER = 2, EV_PLACED = 3} ev_e;
  typedef struct {
    ev_e kind;
    int  len;
    int  score;
    int  hi;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   m_len = 3;
  int   m_score = 0;
  int   m_hi = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic handle(input ev_e kind);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event", int'(kind), 0);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", int'(kind), int'(e.kind));
    case (kind)
      EV_GROW: begin
        check("grow_len", int'(snake_len_o), e.len);
        check("grow_score", int'(score_o), e.score);
        check("grow_apple_vld", int'(apple_vld_o), 0);
        check("grow_run", int'(run_o), 1);
      end
      EV_OVER: begin
        check("over_score", int'(score_o), e.score);
        check("over_hi", int'(hi_score_o), e.hi);
        check("over_run", int'(run_o), 0);
        check("over_len", int'(snake_len_o), e.len);
      end
      default: begin
        check("placed_len", int'(snake_len_o), e.len);
        check("placed_score", int'(score_o), e.score);
        check("placed_x_range", int'(apple_x_o < 6'd32), 1);
        check("placed_y_range", int'(apple_y_o < 6'd24), 1);
        check("placed_run", int'(run_o), 1);
      end
    endcase
  endtask

  // Monitor: reacts only to events the DUT presents.
  logic prev_over = 1'b0;
  logic prev_vld = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_over = 1'b0;
      prev_vld  = 1'b0;
    end else begin
      if (grow_o) handle(EV_GROW);
      if (game_over_o && !prev_over) handle(EV_OVER);
      if (apple_vld_o && !prev_vld) handle(EV_PLACED);
      prev_over = game_over_o;
      prev_vld  = apple_vld_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input ev_e kind);
    exp_t e;
    e.kind  = kind;
    e.len   = m_len;
    e.score = m_score;
    e.hi    = m_hi;
    exp_q.push_back(e);
  endtask

  task automatic wait_vld(input string name);
    bit seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (apple_vld_o) begin
        seen = 1;
        break;
      end
      tick();
    end
    if (!seen) check(name, 0, 1);
  endtask

  task automatic do_start(input int hold);
    m_len   = 3;
    m_score = 0;
    push(EV_PLACED);
    start_i = 1'b1;
    repeat (hold) tick();
    start_i = 1'b0;
    wait_vld("start_place_timeout");
    check("start_over_cleared", int'(game_over_o), 0);
  endtask

  task automatic collect();
    m_len   = (m_len < 63) ? m_len + 1 : 63;
    m_score = (m_score < 255) ? m_score + 1 : 255;
    push(EV_GROW);
    push(EV_PLACED);
    coll_state_i = COLL_APPLE;
    tick();
    coll_state_i = COLL_NONE;
    frame_end_i  = 1'b1;
    tick();
    frame_end_i  = 1'b0;
    wait_vld("grow_place_timeout");
  endtask

  task automatic collide(input bit with_apple, input bit on_frame_end);
`ifdef HIGH_SCORE_EN
    if (m_score > m_hi) m_hi = m_score;
`endif
    push(EV_OVER);
    if (with_apple) begin
      coll_state_i = COLL_APPLE;
      tick();
      coll_state_i = COLL_NONE;
      tick();
    end
    if (!on_frame_end) begin
      coll_state_i = COLL_HIT;
      tick();
      coll_state_i = COLL_NONE;
      tick();
    end
    coll_state_i = on_frame_end ? COLL_HIT : COLL_NONE;
    frame_end_i  = 1'b1;
    tick();
    frame_end_i  = 1'b0;
    coll_state_i = COLL_NONE;
    check("over_flag", int'(game_over_o), 1);
    check("over_run_now", int'(run_o), 0);
    repeat (3) tick();
    check("over_hold_score", int'(score_o), m_score);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] sx, sy;
    #12;
    check("rst_run", int'(run_o), 0);
    check("rst_over", int'(game_over_o), 0);
    check("rst_grow", int'(grow_o), 0);
    check("rst_len", int'(snake_len_o), 3);
    check("rst_score", int'(score_o), 0);
    check("rst_hi", int'(hi_score_o), 0);
    check("rst_vld", int'(apple_vld_o), 0);
    rst_n = 1'b1;
    tick();

    // Game 1: start, one apple, a quiet frame, then apple+collision in one frame.
    do_start(1);
    collect();
    sx = apple_x_o;
    sy = apple_y_o;
    coll_state_i = COLL_NONE;
    repeat (3) tick();
    coll_state_i = COLL_RESET;
    tick();
    coll_state_i = COLL_NONE;
    frame_end_i  = 1'b1;
    tick();
    frame_end_i  = 1'b0;
    tick();
    check("quiet_run", int'(run_o), 1);
    check("quiet_len", int'(snake_len_o), 4);
    check("quiet_score", int'(score_o), 1);
    check("quiet_vld", int'(apple_vld_o), 1);
    check("quiet_x", int'(apple_x_o), int'(sx));
    check("quiet_y", int'(apple_y_o), int'(sy));
    collide(1'b1, 1'b0);

    // Game 2: score 5; start held high across restart.
    do_start(3);
    repeat (5) collect();
    collide(1'b0, 1'b0);

    // Game 3: score 2, collision on the frame_end cycle itself.
    do_start(1);
    repeat (2) collect();
    collide(1'b0, 1'b1);
    check("hi_after_g3", int'(hi_score_o), m_hi);

    // Game 4: saturation of length and score.
    do_start(1);
    repeat (256) collect();
    check("sat_len", int'(snake_len_o), 63);
    check("sat_score", int'(score_o), 255);
    collide(1'b0, 1'b0);

    // Game 5: reset mid-RUN.
    do_start(1);
    repeat (2) collect();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_run", int'(run_o), 0);
    check("mid_rst_over", int'(game_over_o), 0);
    check("mid_rst_grow", int'(grow_o), 0);
    check("mid_rst_len", int'(snake_len_o), 3);
    check("mid_rst_score", int'(score_o), 0);
    check("mid_rst_hi", int'(hi_score_o), 0);
    check("mid_rst_vld", int'(apple_vld_o), 0);
    check("mid_rst_x", int'(apple_x_o), 0);
    repeat (2) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
